times_table_axi_slave: RTL

AXI4-Lite slave that serves the 3-bit × 3-bit times table used by the Ex8 multiplier, which is the AXI4-Lite master. Holds a 64-entry, 6-bit product table, initialised to a×b on reset. Accepts single-beat reads returning the product, and single-beat writes that overwrite table entries. Sits on the memory side of the multiplier's AXI4-Lite link in place of the block-RAM controller.

---
 rtl/times_table_axi_slave.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/times_table_axi_slave.sv
`timescale 1ns/1ps
// times_table_axi_slave
// AXI4-Lite slave holding a 64-entry, 6-bit product table indexed by {a,b}.
// Each entry starts out as a*b after reset and can be overwritten by writes.
// The read and write channels each have their own small FSM and run
// independently of each other, with at most one transaction outstanding
// on each channel.
module times_table_axi_slave #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,

  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_NEED_W,
    W_NEED_AW,
    W_RESP
  } w_state_t;

  // Reset value of table entry i: upper three index bits times lower three.
  function automatic logic [5:0] init_product(input int unsigned i);
    logic [5:0] idx;
    idx = i[5:0];
    return {3'b000, idx[5:3]} * {3'b000, idx[2:0]};
  endfunction

  // Only the bottom 256 bytes of the address space map onto the table.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> 8) == {ADDR_W{1'b0}};
  endfunction

  // Goes high on the first edge after reset; gates every ready output so
  // nothing is accepted while the block is held in reset.
  logic ready_q;

  // Product table.
  logic [5:0] table_q [64];
  logic [5:0] table_d [64];

  // Read channel state and captured response.
  r_state_t   r_state_q, r_state_d;
  logic [5:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d;

  // Write channel state, half-received transaction and response.
  w_state_t   w_state_q, w_state_d;
  logic [5:0] aw_idx_q, aw_idx_d;
  logic       aw_ok_q, aw_ok_d;
  logic [5:0] wd_q, wd_d;
  logic       wstrb0_q, wstrb0_d;
  logic [1:0] bresp_q, bresp_d;

  // Commit request from the write FSM to the table.
  logic       commit;
  logic [5:0] commit_idx;
  logic       commit_ok;
  logic [5:0] commit_data;
  logic       commit_strb;

  logic ar_ok;
  logic aw_ok;

  // Low address bits and unused data/strobe bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{araddr[1:0], awaddr[1:0], wdata, wstrb};

  assign ar_ok = addr_in_range(araddr);
  assign aw_ok = addr_in_range(awaddr);

  assign rdata = {{(DATA_W-6){1'b0}}, rdata_q};
  assign rresp = rresp_q;
  assign bresp = bresp_q;

  // Read FSM: accept one address, present its captured data until rready.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = ready_q;
        if (arvalid && ready_q) begin
          if (ar_ok) begin
            rdata_d = table_q[araddr[7:2]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 6'd0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Write FSM: collect AW and W in either order, commit once both are in,
  // then hold the response until bready.
  always_comb begin
    w_state_d   = w_state_q;
    aw_idx_d    = aw_idx_q;
    aw_ok_d     = aw_ok_q;
    wd_d        = wd_q;
    wstrb0_d    = wstrb0_q;
    bresp_d     = bresp_q;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_ok   = aw_ok_q;
    commit_data = wd_q;
    commit_strb = wstrb0_q;
    case (w_state_q)
      W_IDLE: begin
        awready = ready_q;
        wready  = ready_q;
        if (ready_q && awvalid && wvalid) begin
          commit      = 1'b1;
          commit_idx  = awaddr[7:2];
          commit_ok   = aw_ok;
          commit_data = wdata[5:0];
          commit_strb = wstrb[0];
        end else if (ready_q && awvalid) begin
          aw_idx_d  = awaddr[7:2];
          aw_ok_d   = aw_ok;
          w_state_d = W_NEED_W;
        end else if (ready_q && wvalid) begin
          wd_d      = wdata[5:0];
          wstrb0_d  = wstrb[0];
          w_state_d = W_NEED_AW;
        end
      end
      W_NEED_W: begin
        wready = 1'b1;
        if (wvalid) begin
          commit      = 1'b1;
          commit_data = wdata[5:0];
          commit_strb = wstrb[0];
        end
      end
      W_NEED_AW: begin
        awready = 1'b1;
        if (awvalid) begin
          commit     = 1'b1;
          commit_idx = awaddr[7:2];
          commit_ok  = aw_ok;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
    if (commit) begin
      bresp_d   = commit_ok ? RESP_OKAY : RESP_SLVERR;
      w_state_d = W_RESP;
    end
  end

  // Table next-state: a committed in-range write with byte 0 enabled
  // replaces one entry; a read on the same edge sees the old contents.
  always_comb begin
    for (int i = 0; i < 64; i++) begin
      table_d[i] = table_q[i];
    end
    if (commit && commit_ok && commit_strb) begin
      table_d[commit_idx] = commit_data;
    end
  end

  // State registers; reset aborts both channels and restores the products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      r_state_q <= R_IDLE;
      rdata_q   <= 6'd0;
      rresp_q   <= RESP_OKAY;
      w_state_q <= W_IDLE;
      aw_idx_q  <= 6'd0;
      aw_ok_q   <= 1'b0;
      wd_q      <= 6'd0;
      wstrb0_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int i = 0; i < 64; i++) begin
        table_q[i] <= init_product(i);
      end
    end else begin
      ready_q   <= 1'b1;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      w_state_q <= w_state_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wd_q      <= wd_d;
      wstrb0_q  <= wstrb0_d;
      bresp_q   <= bresp_d;
      for (int i = 0; i < 64; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

endmodule
